// File: rtl/conv3x3_mac.sv
// conv3x3_mac: three-stage pipelined 3x3 signed fixed-point convolution with bias and saturation.
// Build option: define CONV3X3_RELU_EN to clamp negative results to zero in the final stage.
module conv3x3_mac #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  lf_done,
  input  logic [DATA_WIDTH-1:0] w1,
  input  logic [DATA_WIDTH-1:0] w2,
  input  logic [DATA_WIDTH-1:0] w3,
  input  logic [DATA_WIDTH-1:0] w4,
  input  logic [DATA_WIDTH-1:0] w5,
  input  logic [DATA_WIDTH-1:0] w6,
  input  logic [DATA_WIDTH-1:0] w7,
  input  logic [DATA_WIDTH-1:0] w8,
  input  logic [DATA_WIDTH-1:0] w9,
  input  logic                  wt_load,
  input  logic [3:0]            wt_idx,
  input  logic [DATA_WIDTH-1:0] wt_data,
  output logic [DATA_WIDTH-1:0] conv_out,
  output logic                  out_valid,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned RW   = PW + 2;
  localparam int unsigned AW   = PW + 4;
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;
  logic            acc, wt_we, win_valid, win_last;

  logic [8:0][DW-1:0] win;
  logic [8:0][DW-1:0] k_q, k_eff;
  logic [DW-1:0]      bias_q, bias_eff;

  logic [8:0][PW-1:0] prod_q, prod_d;
  logic [DW-1:0]      bias1_q, bias2_q;
  logic               s1_valid_q, s1_last_q;
  logic [2:0][RW-1:0] row_sum_q, row_sum_d;
  logic               s2_valid_q, s2_last_q;

  logic signed [AW-1:0] total, shifted;
  logic [AW-1:0]        bias_sh;
  logic [DW-1:0]        sat;
  logic [DW-1:0]        conv_out_q;
  logic                 out_valid_q, frame_done_q;

  assign win = {w9, w8, w7, w6, w5, w4, w3, w2, w1};

  function automatic logic [RW-1:0] sext_prod(input logic [PW-1:0] p);
    return {{2{p[PW-1]}}, p};
  endfunction

  function automatic logic [AW-1:0] sext_row(input logic [RW-1:0] r);
    return {{2{r[RW-1]}}, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (acc) state_d = StRun;
      StRun:   if (acc && win_last) state_d = StDone;
      StDone:  if (!lf_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc   = enable & lf_done & ((state_q == StIdle) | (state_q == StRun));
    wt_we = wt_load & (state_q != StRun);
    busy  = (state_q == StRun) | s1_valid_q | s2_valid_q | out_valid_q;
  end

  // The window that wakes the FSM is the first full one: newest pixel at (2,2).
  always_comb begin
    cur_col   = (state_q == StIdle) ? ColW'(2) : col_q;
    cur_row   = (state_q == StIdle) ? RowW'(2) : row_q;
    win_valid = cur_col >= ColW'(2);
    win_last  = (cur_row == RowW'(IMG_H - 1)) && (cur_col == ColW'(IMG_W - 1));
    col_d     = col_q;
    row_d     = row_q;
    if (acc) begin
      if (win_last) begin
        col_d = '0;
        row_d = '0;
      end else if (cur_col == ColW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = cur_row + RowW'(1);
      end else begin
        col_d = cur_col + ColW'(1);
        row_d = cur_row;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Kernel and bias registers; a same-cycle write is forwarded to the accepting window
  // ---------------------------------------------------------------------------
  always_comb begin
    k_eff    = k_q;
    bias_eff = bias_q;
    if (wt_we) begin
      if (wt_idx < 4'd9) begin
        k_eff[wt_idx] = wt_data;
      end else if (wt_idx == 4'd9) begin
        bias_eff = wt_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q    <= '0;
      bias_q <= '0;
    end else begin
      k_q    <= k_eff;
      bias_q <= bias_eff;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: products. Operands are sign-extended so the truncated product is the exact signed one.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = {{DW{k_eff[i][DW-1]}}, k_eff[i]} * {{DW{win[i][DW-1]}}, win[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q     <= '0;
      bias1_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      bias1_q    <= bias_eff;
      s1_valid_q <= acc & win_valid;
      s1_last_q  <= acc & win_valid & win_last;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: row sums
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      row_sum_d[j] = sext_prod(prod_q[3*j]) + sext_prod(prod_q[3*j+1])
                   + sext_prod(prod_q[3*j+2]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_sum_q  <= '0;
      bias2_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      row_sum_q  <= row_sum_d;
      bias2_q    <= bias1_q;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: total + bias, floor shift, saturate (optional ReLU)
  // ---------------------------------------------------------------------------
  always_comb begin
    bias_sh = {{(AW - DW){bias2_q[DW-1]}}, bias2_q} << FRAC_BITS;
    total   = sext_row(row_sum_q[0]) + sext_row(row_sum_q[1]) + sext_row(row_sum_q[2]) + bias_sh;
    shifted = total >>> FRAC_BITS;
    // In range when every bit above the result's sign bit matches it.
    if ((shifted[AW-1:DW-1] == '0) || (shifted[AW-1:DW-1] == '1)) begin
      sat = shifted[DW-1:0];
    end else if (shifted[AW-1]) begin
      sat = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      sat = {1'b0, {(DW - 1){1'b1}}};
    end
`ifdef CONV3X3_RELU_EN
    if (sat[DW-1]) begin
      sat = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conv_out_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (s2_valid_q) begin
        conv_out_q <= sat;
      end
      out_valid_q  <= s2_valid_q;
      frame_done_q <= s2_valid_q & s2_last_q;
    end
  end

  assign conv_out   = conv_out_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac: frames of windows driven from a reference image,
// outputs (value, frame_done, arrival cycle) checked against a flat arithmetic model.
module tb_conv3x3_mac;

  localparam int DW    = 32;
  localparam int FRAC  = 16;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [31:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset, enable, lf_done, wt_load;
  logic [3:0]  wt_idx;
  logic [31:0] wt_data, conv_out;
  logic        out_valid, frame_done, busy;
  logic [31:0] tap [9];

  logic signed [31:0] kern [9];
  logic signed [31:0] bias_m;
  logic signed [31:0] img [IMG_H][IMG_W];

  ev_t         obs[$];
  ev_t         exp_q[$];
  logic [31:0] cyc = '0;
  logic        busy_seen;
  int          n_cmp = 0;
  int          n_fail = 0;

  conv3x3_mac #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FRAC),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .lf_done   (lf_done),
    .w1        (tap[0]),
    .w2        (tap[1]),
    .w3        (tap[2]),
    .w4        (tap[3]),
    .w5        (tap[4]),
    .w6        (tap[5]),
    .w7        (tap[6]),
    .w8        (tap[7]),
    .w9        (tap[8]),
    .wt_load   (wt_load),
    .wt_idx    (wt_idx),
    .wt_data   (wt_data),
    .conv_out  (conv_out),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (busy) busy_seen <= 1'b1;
    if (out_valid || frame_done) obs.push_back('{conv_out, frame_done, cyc});
  end

  // Reference: exact sum of products plus bias, floor-divided, clamped to the output range.
  function automatic logic [31:0] ref_pix(input int r, input int c);
    logic signed [127:0] s, lo, hi;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + 128'(kern[i]) * 128'(img[r - 2 + i / 3][c - 2 + i % 3]);
    s  = s + (128'(bias_m) <<< FRAC);
    s  = s >>> FRAC;
    hi = (128'sd1 <<< 31) - 128'sd1;
    lo = -(128'sd1 <<< 31);
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
`ifdef CONV3X3_RELU_EN
    if (s < 0) s = '0;
`endif
    return s[31:0];
  endfunction

  task automatic fill_img(input int mode);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        case (mode)
          0:       img[r][c] = (r * 32 + c) << 16;
          1:       img[r][c] = 32'sh0002_0000;
          2:       img[r][c] = 32'sh7FFF_0000;
          3:       img[r][c] = int'($urandom_range(0, 1048575)) - 524288;
          default: img[r][c] = $urandom();
        endcase
      end
    end
  endtask

  task automatic rand_kernel();
    for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 1048575)) - 524288;
    bias_m = int'($urandom_range(0, 1048575)) - 524288;
  endtask

  // Writes the model kernel/bias into the DUT, then pokes the unused addresses.
  task automatic load_weights();
    enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wt_load = 1'b1;
      wt_idx  = 4'(i);
      wt_data = (i < 9) ? kern[i] : ((i == 9) ? bias_m : $urandom());
      @(posedge clk); #1;
    end
    wt_load = 1'b0;
  endtask

  // en_mode: 0 continuous, 1 toggle, 2 random enable/lf_done gaps.
  // wl_mode: 1 writes k5 on the first window slot, 2 writes k5 mid-frame (must be ignored).
  task automatic drive_frame(input int en_mode, input int max_obs, input int wl_mode,
                             input logic [31:0] wl_data, output bit cut);
    int p, nwin, lin, r, c, guard;
    bit en;
    nwin  = IMG_H * IMG_W - (2 * IMG_W + 2);
    p     = 0;
    guard = 0;
    cut   = 1'b0;
    en    = 1'b0;
    while (p < nwin) begin
      if (max_obs > 0 && obs.size() >= max_obs) begin
        cut = 1'b1;
        break;
      end
      if (++guard > 40000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL frame_guard: got %0d accepted, expected %0d", p, nwin);
        break;
      end
      lin = 2 * IMG_W + 2 + p;
      r   = lin / IMG_W;
      c   = lin % IMG_W;
      case (en_mode)
        0:       begin en = 1'b1; lf_done = 1'b1; end
        1:       begin en = ~en; lf_done = 1'b1; end
        default: begin en = ($urandom_range(0, 3) != 0); lf_done = ($urandom_range(0, 4) != 0); end
      endcase
      enable  = en;
      wt_load = 1'b0;
      if ((wl_mode == 1 && p == 0) || (wl_mode == 2 && p == 50)) begin
        wt_load = 1'b1;
        wt_idx  = 4'd4;
        wt_data = wl_data;
        if (wl_mode == 1) kern[4] = wl_data;
      end
      for (int i = 0; i < 9; i++) begin
        if (c >= 2) tap[i] = img[r - 2 + i / 3][c - 2 + i % 3];
        else tap[i] = $urandom();
      end
      if (enable && lf_done) begin
        if (c >= 2) exp_q.push_back('{ref_pix(r, c), (p == nwin - 1), cyc + 32'd3});
        p++;
      end
      @(posedge clk); #1;
    end
    wt_load = 1'b0;
    if (!cut) begin
      enable  = 1'b0;
      lf_done = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; lf_done = 1'b0; wt_load = 1'b0; wt_idx = '0; wt_data = '0;
    for (int i = 0; i < 9; i++) begin tap[i] = '0; kern[i] = '0; end
    bias_m = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if (conv_out !== 32'd0) begin n_fail++; $display("FAIL rst_conv_out: got %h expected 0", conv_out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_identity();
    bit cut;
    logic [31:0] first, last_d;
    logic        last_f;
    for (int i = 0; i < 9; i++) kern[i] = '0;
    kern[4] = 32'sh0001_0000;
    bias_m  = '0;
    load_weights();
    fill_img(0);
    obs.delete(); exp_q.delete();
    drive_frame(0, 0, 0, '0, cut);
    first  = (obs.size() > 0) ? obs[0].data : 'x;
    last_d = (obs.size() > 0) ? obs[obs.size() - 1].data : 'x;
    last_f = (obs.size() > 0) ? obs[obs.size() - 1].last : 1'bx;
    n_cmp++; if (obs.size() !== 900) begin n_fail++; $display("FAIL ident_count: got %0d expected 900", obs.size()); end
    n_cmp++; if (first !== 32'h0021_0000) begin n_fail++; $display("FAIL ident_first: got %h expected 00210000", first); end
    n_cmp++; if (last_d !== 32'h03DE_0000) begin n_fail++; $display("FAIL ident_last: got %h expected 03de0000", last_d); end
    n_cmp++; if (last_f !== 1'b1) begin n_fail++; $display("FAIL ident_frame_done: got %b expected 1", last_f); end
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL ident_model_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ident_out[%0d]: got %h/%b@%0d expected %h/%b@%0d", i, obs[i].data, obs[i].last,
                 obs[i].cyc, exp_q[i].data, exp_q[i].last, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_bias_latency();
    bit cut;
    logic [31:0] first;
    for (int i = 0; i < 9; i++) kern[i] = 32'sh0001_0000;
    bias_m = 32'sh0000_8000;
    load_weights();
    fill_img(1);
    obs.delete(); exp_q.delete();
    busy_seen = 1'b0;
    drive_frame(0, 0, 0, '0, cut);
    first = (obs.size() > 0) ? obs[0].data : 'x;
    n_cmp++; if (first !== 32'h0012_8000) begin n_fail++; $display("FAIL bias_first: got %h expected 00128000", first); end
    n_cmp++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL bias_busy_run: got %b expected 1", busy_seen); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bias_busy_idle: got %b expected 0", busy); end
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL bias_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bias_out[%0d]: got %h/%b@%0d expected %h/%b@%0d", i, obs[i].data, obs[i].last,
                 obs[i].cyc, exp_q[i].data, exp_q[i].last, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_saturation();
    bit cut;
    logic [31:0] pos_v, neg_v, neg_req;
`ifdef CONV3X3_RELU_EN
    neg_req = 32'h0000_0000;
`else
    neg_req = 32'h8000_0000;
`endif
    fill_img(2);
    obs.delete(); exp_q.delete();
    for (int i = 0; i < 9; i++) kern[i] = 32'sh7FFF_0000;
    bias_m = '0;
    load_weights();
    drive_frame(0, 0, 0, '0, cut);
    pos_v = (obs.size() > 0) ? obs[0].data : 'x;
    for (int i = 0; i < 9; i++) kern[i] = -32'sh7FFF_0000;
    load_weights();
    drive_frame(0, 0, 0, '0, cut);
    neg_v = (obs.size() > 900) ? obs[900].data : 'x;
    n_cmp++; if (pos_v !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_pos: got %h expected 7fffffff", pos_v); end
    n_cmp++; if (neg_v !== neg_req) begin n_fail++; $display("FAIL sat_neg: got %h expected %h", neg_v, neg_req); end
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sat_out[%0d]: got %h/%b@%0d expected %h/%b@%0d", i, obs[i].data, obs[i].last,
                 obs[i].cyc, exp_q[i].data, exp_q[i].last, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_enable_gaps();
    bit cut;
    rand_kernel();
    load_weights();
    fill_img(3);
    obs.delete(); exp_q.delete();
    drive_frame(1, 0, 0, '0, cut);
    fill_img(4);
    drive_frame(2, 0, 0, '0, cut);
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL gaps_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gaps_out[%0d]: got %h/%b@%0d expected %h/%b@%0d", i, obs[i].data, obs[i].last,
                 obs[i].cyc, exp_q[i].data, exp_q[i].last, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_wt_load();
    bit cut;
    rand_kernel();
    load_weights();
    fill_img(3);
    obs.delete(); exp_q.delete();
    drive_frame(0, 0, 2, 32'h0005_0000, cut);
    drive_frame(0, 0, 1, 32'h0005_0000, cut);
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL wt_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wt_out[%0d]: got %h/%b@%0d expected %h/%b@%0d", i, obs[i].data, obs[i].last,
                 obs[i].cyc, exp_q[i].data, exp_q[i].last, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit cut;
    ev_t tail;
    rand_kernel();
    load_weights();
    fill_img(3);
    obs.delete(); exp_q.delete();
    drive_frame(0, 100, 0, '0, cut);
    reset = 1'b1;
    // Anything that would surface after the reset edge is lost.
    while (exp_q.size() > 0) begin
      tail = exp_q[exp_q.size() - 1];
      if (tail.cyc > cyc) void'(exp_q.pop_back());
      else break;
    end
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b0; lf_done = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b expected 0", busy); end
    for (int i = 0; i < 9; i++) kern[i] = '0;
    bias_m = '0;
    repeat (4) @(posedge clk);
    #1;
    fill_img(4);
    drive_frame(0, 0, 0, '0, cut);
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL mrst_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mrst_out[%0d]: got %h/%b@%0d expected %h/%b@%0d", i, obs[i].data, obs[i].last,
                 obs[i].cyc, exp_q[i].data, exp_q[i].last, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_bias_latency();
    test_saturation();
    test_enable_gaps();
    test_wt_load();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
